// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: N_CH independent channels (off / on / blink / counted burst)
// paced by one shared tick prescaler and configured one channel per write strobe.
module led_blink_multi #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned N_CH     = 8,
    parameter int unsigned PER_W    = 16,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [PER_W-1:0] cfg_on_ticks,
    input  logic [PER_W-1:0] cfg_off_ticks,
    input  logic [CNT_W-1:0] cfg_repeat,
    output logic [N_CH-1:0]  leds,
    output logic [N_CH-1:0]  busy,
    output logic [N_CH-1:0]  done
);

    localparam int unsigned DIV_RAW = CLK_FREQ / TICK_HZ;
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned PS_W    = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ON    = 2'd1,
        M_BLINK = 2'd2,
        M_BURST = 2'd3
    } mode_t;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    logic [PS_W-1:0] ps_cnt;
    logic            tick;
    mode_t           cfg_mode_e;

    assign tick       = (ps_cnt == PS_W'(DIV - 1));
    assign cfg_mode_e = mode_t'(cfg_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mode_t            mode_q, mode_d;
        phase_t           phase_q, phase_d;
        logic [PER_W-1:0] on_q, on_d, off_q, off_d, pcnt_q, pcnt_d;
        logic [CNT_W-1:0] rep_q, rep_d, rcnt_q, rcnt_d;
        logic             led_q, led_d, done_q, done_d;
        logic             wr;

        assign wr = cfg_we && (cfg_ch == CH_W'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q  <= M_OFF;
                phase_q <= PH_ON;
                on_q    <= PER_W'(1);
                off_q   <= PER_W'(1);
                pcnt_q  <= '0;
                rep_q   <= '0;
                rcnt_q  <= '0;
                led_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                mode_q  <= mode_d;
                phase_q <= phase_d;
                on_q    <= on_d;
                off_q   <= off_d;
                pcnt_q  <= pcnt_d;
                rep_q   <= rep_d;
                rcnt_q  <= rcnt_d;
                led_q   <= led_d;
                done_q  <= done_d;
            end
        end

        // A write wins over the tick update, which also drops any done due this cycle.
        always_comb begin
            mode_d  = mode_q;
            phase_d = phase_q;
            on_d    = on_q;
            off_d   = off_q;
            pcnt_d  = pcnt_q;
            rep_d   = rep_q;
            rcnt_d  = rcnt_q;
            led_d   = led_q;
            done_d  = 1'b0;
            if (wr) begin
                mode_d  = cfg_mode_e;
                on_d    = (cfg_on_ticks == '0) ? PER_W'(1) : cfg_on_ticks;
                off_d   = (cfg_off_ticks == '0) ? PER_W'(1) : cfg_off_ticks;
                rep_d   = cfg_repeat;
                phase_d = PH_ON;
                pcnt_d  = '0;
                rcnt_d  = '0;
                led_d   = (cfg_mode_e != M_OFF) && !((cfg_mode_e == M_BURST) && (cfg_repeat == '0));
            end else if ((mode_q == M_BURST) && (rep_q == '0)) begin
                mode_d = M_OFF;
                led_d  = 1'b0;
                done_d = 1'b1;
            end else if (tick && ((mode_q == M_BLINK) || (mode_q == M_BURST))) begin
                if (phase_q == PH_ON) begin
                    if (pcnt_q == on_q - 1'b1) begin
                        pcnt_d  = '0;
                        phase_d = PH_OFF;
                        led_d   = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end else begin
                    if (pcnt_q == off_q - 1'b1) begin
                        pcnt_d  = '0;
                        phase_d = PH_ON;
                        if (mode_q == M_BLINK) begin
                            led_d = 1'b1;
                        end else if (({1'b0, rcnt_q} + 1'b1) == {1'b0, rep_q}) begin
                            mode_d = M_OFF;
                            led_d  = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                            led_d  = 1'b1;
                        end
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end
        end

        assign leds[g] = led_q;
        assign done[g] = done_q;
        assign busy[g] = (mode_q == M_BLINK) || (mode_q == M_BURST);
    end

endmodule
